// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types for the pipeline trace buffer: session states and the record layout.
package pipe_trace_buffer_pkg;

    localparam int REC_W = 96;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
    } trace_rec_t;

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Tap, control and read-port bundle between a debug host (master) and the trace buffer (slave).
interface pipe_trace_buffer_if
    import pipe_trace_buffer_pkg::*;
#(
    parameter int AW = 4
);
    logic        arm;
    logic [31:0] trig_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic        rd_en;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [31:0] rd_alu;
    logic        rd_valid;
    logic [AW:0] count;
    state_e      state;
    logic        triggered;

    modport master (
        output arm, trig_pc, pc, inst, alu, rd_en,
        input  rd_pc, rd_inst, rd_alu, rd_valid, count, state, triggered
    );

    modport slave (
        input  arm, trig_pc, pc, inst, alu, rd_en,
        output rd_pc, rd_inst, rd_alu, rd_valid, count, state, triggered
    );

endinterface

// File: rtl/pipe_trace_buffer_trace_ram.sv
// DEPTH x 96 record store: synchronous write, registered read that holds when not read.
module pipe_trace_buffer_trace_ram
    import pipe_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  trace_rec_t    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output trace_rec_t    rdata_o
);

    trace_rec_t mem_q [DEPTH];
    trace_rec_t rdata_q;

    // Array contents are never reset; only the read register has a defined reset value.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register updates only on an accepted read so the last record stays visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace recorder for PC / fetched instruction / write-back ALU with PC trigger.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no session; waits for arm
// ST_ARMED   | sampling every cycle, watching for pc == trig_pc
// ST_CAPTURE | trigger seen; sampling the post-trigger window
// ST_DONE    | capture frozen; records drained oldest-first via rd_en
module pipe_trace_buffer
    import pipe_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 8
) (
    input logic             clk_i,
    input logic             rst_i,
    pipe_trace_buffer_if.slave bus
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_C  = AW'(POST);

    state_e        state_q;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [AW-1:0] post_q;
    logic [AW:0]   count_q;
    logic          trig_q;
    logic          rd_valid_q;

    logic [AW-1:0] wp_inc;
    logic [AW:0]   count_inc;
    logic          hit;
    logic          we;
    logic          re;
    trace_rec_t    wdata;
    trace_rec_t    rdata;

    assign wp_inc    = wp_q + 1'b1;
    assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
    assign hit       = (bus.pc == bus.trig_pc);
    // Arm wins over both sampling and reading in the same cycle.
    assign we        = !bus.arm && ((state_q == ST_ARMED) || (state_q == ST_CAPTURE));
    assign re        = !bus.arm && (state_q == ST_DONE) && bus.rd_en && (count_q != '0);
    assign wdata     = '{pc: bus.pc, inst: bus.inst, alu: bus.alu};

    pipe_trace_buffer_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .waddr_i (wp_q),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i (rp_q),
        .rdata_o (rdata)
    );

    // Session FSM with write/read pointers, occupancy and post-trigger down-counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            post_q     <= '0;
            count_q    <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (bus.arm) begin
                state_q <= ST_ARMED;
                wp_q    <= '0;
                rp_q    <= '0;
                count_q <= '0;
                trig_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                    end
                    ST_ARMED: begin
                        wp_q    <= wp_inc;
                        count_q <= count_inc;
                        if (hit) begin
                            trig_q <= 1'b1;
                            if (POST == 0) begin
                                state_q <= ST_DONE;
                                rp_q    <= wp_inc - count_inc[AW-1:0];
                            end else begin
                                state_q <= ST_CAPTURE;
                                post_q  <= POST_C;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        wp_q    <= wp_inc;
                        count_q <= count_inc;
                        post_q  <= post_q - 1'b1;
                        // A full buffer makes wp the oldest slot, so count mod DEPTH still lands right.
                        if (post_q == AW'(1)) begin
                            state_q <= ST_DONE;
                            rp_q    <= wp_inc - count_inc[AW-1:0];
                        end
                    end
                    ST_DONE: begin
                        if (re) begin
                            rd_valid_q <= 1'b1;
                            rp_q       <= rp_q + 1'b1;
                            count_q    <= count_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.rd_pc     = rdata.pc;
    assign bus.rd_inst   = rdata.inst;
    assign bus.rd_alu    = rdata.alu;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.count     = count_q;
    assign bus.state     = state_q;
    assign bus.triggered = trig_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: two instances (POST=8 and POST=0) on shared stimulus,
// each checked every cycle against a queue-based session model.
module tb_pipe_trace_buffer;
    import pipe_trace_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        rd_en;
    logic [31:0] trig_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pipe_trace_buffer_if #(.AW(AW)) if8 ();
    pipe_trace_buffer_if #(.AW(AW)) if0 ();

    assign if8.arm = arm;   assign if0.arm = arm;
    assign if8.trig_pc = trig_pc; assign if0.trig_pc = trig_pc;
    assign if8.pc = pc;     assign if0.pc = pc;
    assign if8.inst = inst; assign if0.inst = inst;
    assign if8.alu = alu;   assign if0.alu = alu;
    assign if8.rd_en = rd_en; assign if0.rd_en = rd_en;

    pipe_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST(8)) dut8 (
        .clk_i (clk), .rst_i (rst), .bus (if8)
    );
    pipe_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST(0)) dut0 (
        .clk_i (clk), .rst_i (rst), .bus (if0)
    );

    // ---------------- behavioural model (index 0: POST=8, index 1: POST=0)
    int          m_state [2];
    bit          m_trig  [2];
    int          m_seen  [2];
    logic [95:0] m_q     [2][$];
    logic [95:0] m_rd    [2];
    bit          m_rv    [2];

    task automatic model_step(input int i, input int post);
        m_rv[i] = 1'b0;
        if (rst) begin
            m_state[i] = 0; m_q[i].delete(); m_trig[i] = 1'b0; m_rd[i] = '0;
        end else if (arm) begin
            m_state[i] = 1; m_q[i].delete(); m_trig[i] = 1'b0;
        end else if (m_state[i] == 1 || m_state[i] == 2) begin
            m_q[i].push_back({pc, inst, alu});
            if (m_q[i].size() > DEPTH) void'(m_q[i].pop_front());
            if (m_state[i] == 1) begin
                if (pc == trig_pc) begin
                    m_trig[i] = 1'b1;
                    m_seen[i] = 0;
                    m_state[i] = (post == 0) ? 3 : 2;
                end
            end else begin
                m_seen[i] = m_seen[i] + 1;
                if (m_seen[i] == post) m_state[i] = 3;
            end
        end else if (m_state[i] == 3 && rd_en && m_q[i].size() > 0) begin
            m_rd[i] = m_q[i].pop_front();
            m_rv[i] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 8);
        model_step(1, 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("p8_state", 32'(if8.state), 32'(m_state[0]));
            chk("p8_count", 32'(if8.count), 32'(m_q[0].size()));
            chk("p8_trig",  32'(if8.triggered), 32'(m_trig[0]));
            chk("p8_rdv",   32'(if8.rd_valid), 32'(m_rv[0]));
            chk("p8_rdpc",  if8.rd_pc,   m_rd[0][95:64]);
            chk("p8_rdin",  if8.rd_inst, m_rd[0][63:32]);
            chk("p8_rdalu", if8.rd_alu,  m_rd[0][31:0]);
            chk("p0_state", 32'(if0.state), 32'(m_state[1]));
            chk("p0_count", 32'(if0.count), 32'(m_q[1].size()));
            chk("p0_trig",  32'(if0.triggered), 32'(m_trig[1]));
            chk("p0_rdv",   32'(if0.rd_valid), 32'(m_rv[1]));
            chk("p0_rdpc",  if0.rd_pc,   m_rd[1][95:64]);
            chk("p0_rdin",  if0.rd_inst, m_rd[1][63:32]);
            chk("p0_rdalu", if0.rd_alu,  m_rd[1][31:0]);
        end
    end

    // ---------------- stimulus helpers (called at a falling edge)
    task automatic drive(input bit a, input bit r, input logic [31:0] p);
        arm   = a;
        rd_en = r;
        pc    = p;
        inst  = $urandom;
        alu   = $urandom;
        @(negedge clk);
    endtask

    task automatic run_capture(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b0, 32'(4 * k));
            n = k + 1;
            if (if8.state == ST_DONE) break;
        end
    endtask

    task automatic read_expect(input string name, input int nrec, input logic [31:0] first_pc);
        for (int k = 0; k < nrec; k++) begin
            drive(1'b0, 1'b1, 32'h0000_1000);
            chk({name, "_rdv"}, 32'(if8.rd_valid), 32'd1);
            chk({name, "_rdpc"}, if8.rd_pc, first_pc + 32'(4 * k));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; arm = 1'b0; rd_en = 1'b0; trig_pc = '0;
        pc = '0; inst = '0; alu = '0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_state", 32'(if8.state), 32'd0);
        chk("reset_count", 32'(if8.count), 32'd0);
        rst = 1'b0;

        // 1: trigger at 0x20, 17 samples, 16 retained
        trig_pc = 32'h20;
        drive(1'b1, 1'b0, 32'hdead_0000);
        run_capture(n);
        chk("t1_samples", 32'(n), 32'd17);
        chk("t1_state", 32'(if8.state), 32'd3);
        chk("t1_count", 32'(if8.count), 32'd16);
        chk("t1_model_cnt", 32'(m_q[0].size()), 32'd16);
        read_expect("t1", 16, 32'h04);

        // 2: trigger at 0x08, 11 samples, then one read too many
        trig_pc = 32'h08;
        drive(1'b1, 1'b0, 32'hdead_0000);
        run_capture(n);
        chk("t2_samples", 32'(n), 32'd11);
        chk("t2_count", 32'(if8.count), 32'd11);
        read_expect("t2", 11, 32'h00);
        drive(1'b0, 1'b1, 32'h0000_1000);
        chk("t2_extra_rdv", 32'(if8.rd_valid), 32'd0);
        chk("t2_extra_cnt", 32'(if8.count), 32'd0);
        chk("t2_hold_pc", if8.rd_pc, 32'h28);

        // 3: trigger never hit
        trig_pc = 32'hffff_fff0;
        drive(1'b1, 1'b0, 32'hdead_0000);
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 32'(4 * k));
        chk("t3_state", 32'(if8.state), 32'd1);
        chk("t3_count", 32'(if8.count), 32'd16);
        chk("t3_trig", 32'(if8.triggered), 32'd0);
        drive(1'b0, 1'b1, 32'h0000_1000);
        chk("t3_rdv", 32'(if8.rd_valid), 32'd0);

        // 4: POST=0 instance, trigger on first sample
        trig_pc = 32'h0;
        drive(1'b1, 1'b0, 32'hdead_0000);
        drive(1'b0, 1'b0, 32'h0);
        chk("t4_state", 32'(if0.state), 32'd3);
        chk("t4_count", 32'(if0.count), 32'd1);
        drive(1'b0, 1'b1, 32'h4);
        chk("t4_rdv", 32'(if0.rd_valid), 32'd1);
        chk("t4_rdpc", if0.rd_pc, 32'h0);

        // 5: reset mid-capture, then trigger PC without arm
        trig_pc = 32'h08;
        drive(1'b1, 1'b0, 32'hdead_0000);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 32'(4 * k));
        chk("t5_capture", 32'(if8.state), 32'd2);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h14);
        rst = 1'b0;
        chk("t5_state", 32'(if8.state), 32'd0);
        chk("t5_count", 32'(if8.count), 32'd0);
        chk("t5_trig", 32'(if8.triggered), 32'd0);
        chk("t5_rdv", 32'(if8.rd_valid), 32'd0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 32'h08);
        chk("t5_idle", 32'(if8.state), 32'd0);
        chk("t5_idle_cnt", 32'(if8.count), 32'd0);

        // 6: arm together with rd_en after 3 of 11 reads, then a fresh session
        drive(1'b1, 1'b0, 32'hdead_0000);
        run_capture(n);
        read_expect("t6a", 3, 32'h00);
        drive(1'b1, 1'b1, 32'hdead_0000);
        chk("t6_rdv", 32'(if8.rd_valid), 32'd0);
        chk("t6_state", 32'(if8.state), 32'd1);
        chk("t6_count", 32'(if8.count), 32'd0);
        run_capture(n);
        chk("t6_samples", 32'(n), 32'd11);
        read_expect("t6b", 11, 32'h00);

        // random traffic, model-checked every cycle
        for (int c = 0; c < 3000; c++) begin
            bit a;
            rst = ($urandom_range(0, 499) == 0);
            a = ($urandom_range(0, 49) == 0);
            if (a) trig_pc = 32'(4 * $urandom_range(0, 15));
            drive(a, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)));
            rst = 1'b0;
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
